rv32_muldiv_unit: RTL and testbench
===================================

Name: rv32_muldiv_unit

Overview:
Iterative/multi-cycle RV32M execution unit for the exec stage. It generalises the existing mul_op_t support to the full M extension: MUL/MULH/MULHSU/MULHU plus DIV/DIVU/REM/REMU. It is parametrised in divider radix and multiplier latency, and uses valid/ready handshakes on both sides. It returns a 32-bit result tagged with the destination register id, feeding the WB_MUL_UNIT writeback source.

Parameters:
DIV_BITS_PER_CYCLE, 1, quotient bits retired per divide iteration; legal values 1, 2, 4 (elaboration error otherwise).
MUL_LATENCY, 2, cycles from request accept to result valid for multiplies; legal range 1..4.

Ports:
clk  in  1  core clock
rstn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_op  in  3  md_op_t, encoded as funct3 of OP with funct7=0000001
req_rs1  in  32  operand A (rv32_word)
req_rs2  in  32  operand B (rv32_word)
req_rd  in  5  destination tag (rv_reg_id_t)
flush  in  1  abort any in-flight operation
resp_valid  out  1  result present
resp_ready  in  1  consumer takes result
resp_data  out  32  result
resp_rd  out  5  tag of the result
busy  out  1  high in any state except IDLE; used by the hazard unit

Behaviour:
- Reset (async, rstn=0): state=IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_rd=0, busy=0, iteration counter=0.
- States: IDLE, MUL, DIV, FIXUP, DONE.
- Handshake: accept on req_valid&req_ready. req_ready=1 only in IDLE. The unit holds one operation and has no queue.
- resp_valid is high only in DONE. resp_data and resp_rd are held stable until resp_valid&resp_ready; then the state returns to IDLE. There is no same-cycle re-accept, so throughput is at most one op per latency+1.
- MUL path: the full 64-bit product is formed from 33-bit sign/zero-extended operands. MULHSU: rs1 signed, rs2 unsigned. MUL returns bits [31:0]; the MULH variants return [63:32]. MUL state lasts MUL_LATENCY cycles, so resp_valid asserts MUL_LATENCY cycles after accept.
- DIV path: operands are converted to magnitudes on accept, with signs recorded for DIV/REM. The restoring divider runs 32/DIV_BITS_PER_CYCLE iterations in DIV, followed by 1 cycle in FIXUP to apply signs: the quotient is negated if the operand signs differ, and the remainder takes the sign of the dividend. resp_valid asserts 32/DIV_BITS_PER_CYCLE+1 cycles after accept.
- Special cases, detected on accept; they go straight to DONE, so resp_valid asserts the next cycle:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): DIV gives 0x80000000, REM gives 0.
- flush: from any state, next state=IDLE, resp_valid=0 next cycle, and the counter is cleared.
  - flush has priority over a simultaneous resp handshake and over a simultaneous accept; the request is dropped and req_ready is still 1 that cycle.
- Asynchronous reset mid-operation returns every output to its reset value immediately.
- rs1/rs2 equal to x0 tags need no special handling; resp_rd=0 results are still presented.

Optional Feature:
RV32_MULDIV_RESULT_REUSE_EN.
- Defined: the unit keeps the last completed divide's operands, signedness, quotient and remainder (valid bit cleared by reset and by flush). A DIV*/REM* request with identical rs1, rs2 and signedness returns the stored quotient or remainder via DONE on the next cycle, with no iterations (DIV then REM fusion).
- Not defined: no storage is built, and every divide takes the full latency.

Decomposition:
- Add to rv32_types:
  - md_op_t enum (MD_MUL=3'b000, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV=3'b100, MD_DIVU, MD_REM, MD_REMU)
  - md_state_t enum
  - md_request_t struct (op, rs1, rs2, rd)
- Sub-module rv32_div_iter: holds the combinational single-iteration step, DIV_BITS_PER_CYCLE wide. The top module instantiates it once and owns the FSM and registers.

Test Plan:
1. MULH: rs1=0xFFFFFFFE (-2), rs2=0x00000003, MUL_LATENCY=2 -> resp_data=0xFFFFFFFF after 2 cycles. MULHU with the same operands -> 0x00000002.
2. DIV: rs1=0xFFFFFFF9 (-7), rs2=2, DIV_BITS_PER_CYCLE=1 -> resp_data=0xFFFFFFFD (-3) at cycle 33. REM with the same operands -> 0xFFFFFFFF (-1).
3. DIVU: rs1=100, rs2=0 -> resp_data=0xFFFFFFFF next cycle. REMU with the same operands -> 100. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
4. DIVU 1000/7 with resp_ready held low 5 cycles after valid -> resp_data=142 and resp_rd stable throughout, req_ready=0 until the handshake completes.
5. flush asserted at iteration 10 of a divide -> resp_valid never asserts and req_ready=1 next cycle. A new MUL 6*7 then returns 42.
6. With RV32_MULDIV_RESULT_REUSE_EN: DIV 1000/7 then REM 1000/7 -> 142, then 6 one cycle after accept. Without the macro the REM takes 33 cycles.

Source files
------------

// File: rtl/rv32_muldiv_unit_pkg.sv
// Shared types for the RV32M multiply/divide unit: operation encoding
// (funct3 of OP with funct7=0000001), FSM states and the held request.
package rv32_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIXUP,
    ST_DONE
  } md_state_t;

  typedef struct packed {
    md_op_t      op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } md_request_t;

  // Two's complement negate when en is set (used for magnitudes and sign fixup).
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/rv32_muldiv_unit_div_iter.sv
// Combinational restoring-divide step: retires DIV_BITS_PER_CYCLE quotient
// bits per call. The dividend is shifted out of the quotient register MSB
// first while quotient bits are shifted in at the LSB.
module rv32_div_iter #(
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic [31:0] rem_in,
  input  logic [31:0] quo_in,
  input  logic [31:0] divisor,
  output logic [31:0] rem_out,
  output logic [31:0] quo_out
);

  logic [32:0] trial;
  logic [31:0] r;
  logic [31:0] q;

  // Unrolled shift/compare/subtract for each retired quotient bit
  always_comb begin
    r     = rem_in;
    q     = quo_in;
    trial = '0;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      trial = {r, q[31]};
      q     = {q[30:0], 1'b0};
      if (trial >= {1'b0, divisor}) begin
        trial = trial - {1'b0, divisor};
        q[0]  = 1'b1;
      end
      r = trial[31:0];
    end
    rem_out = r;
    quo_out = q;
  end

endmodule

// File: rtl/rv32_muldiv_unit.sv
// RV32M execution unit: MUL/MULH/MULHSU/MULHU via a fixed-latency product,
// DIV/DIVU/REM/REMU via an iterative restoring divider with sign fixup.
// Optional macro RV32_MULDIV_RESULT_REUSE_EN keeps the last divide's
// quotient/remainder so a following DIV/REM pair on the same operands
// completes without iterating.
module rv32_muldiv_unit
  import rv32_muldiv_unit_pkg::*;
#(
  parameter int DIV_BITS_PER_CYCLE = 1,
  parameter int MUL_LATENCY        = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        busy
);

  localparam int DIV_ITERS = 32 / DIV_BITS_PER_CYCLE;

  if (DIV_BITS_PER_CYCLE != 1 && DIV_BITS_PER_CYCLE != 2 && DIV_BITS_PER_CYCLE != 4) begin : g_bad_radix
    $error("DIV_BITS_PER_CYCLE must be 1, 2 or 4");
  end
  if (MUL_LATENCY < 1 || MUL_LATENCY > 4) begin : g_bad_mul_lat
    $error("MUL_LATENCY must be in 1..4");
  end

  md_state_t   state;
  logic [5:0]  cnt;
  md_request_t req_q;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvs_q;
  logic        q_neg;
  logic        r_neg;

  logic        in_signed;
  logic        in_rem;
  logic        div_zero;
  logic        div_ovf;
  logic [31:0] special_res;
  logic [31:0] iter_rem;
  logic [31:0] iter_quo;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  logic signed [32:0] mul_a;
  logic signed [32:0] mul_b;
  logic signed [63:0] prod;
  logic [31:0]        mul_res;

  logic        reuse_hit;
  logic [31:0] reuse_q;
  logic [31:0] reuse_r;

  assign in_signed = ~req_op[0];
  assign in_rem    = req_op[1];
  assign div_zero  = (req_rs2 == 32'd0);
  assign div_ovf   = in_signed && (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF);

  // Operands widened to 33 bits so one signed multiply covers all four variants
  assign mul_a   = {(req_q.op != MD_MULHU) & req_q.rs1[31], req_q.rs1};
  assign mul_b   = {((req_q.op == MD_MUL) || (req_q.op == MD_MULH)) & req_q.rs2[31], req_q.rs2};
  assign prod    = 64'(mul_a) * 64'(mul_b);
  assign mul_res = (req_q.op == MD_MUL) ? prod[31:0] : prod[63:32];

  assign q_fix = neg_if(quo_q, q_neg);
  assign r_fix = neg_if(rem_q, r_neg);

  rv32_div_iter #(.DIV_BITS_PER_CYCLE(DIV_BITS_PER_CYCLE)) u_div_iter (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (iter_rem),
    .quo_out (iter_quo)
  );

`ifdef RV32_MULDIV_RESULT_REUSE_EN
  logic        reuse_vld;
  logic        reuse_sgn;
  logic [31:0] reuse_a;
  logic [31:0] reuse_b;

  assign reuse_hit = reuse_vld && (req_rs1 == reuse_a) && (req_rs2 == reuse_b) &&
                     (in_signed == reuse_sgn);

  // Stored divide result becomes valid when a full divide finishes its fixup
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                   reuse_vld <= 1'b0;
    else if (flush)              reuse_vld <= 1'b0;
    else if (state == ST_FIXUP)  reuse_vld <= 1'b1;
  end

  // Capture operands and signed results of the completed divide
  always_ff @(posedge clk) begin
    if (state == ST_FIXUP) begin
      reuse_a   <= req_q.rs1;
      reuse_b   <= req_q.rs2;
      reuse_sgn <= ~req_q.op[0];
      reuse_q   <= q_fix;
      reuse_r   <= r_fix;
    end
  end
`else
  assign reuse_hit = 1'b0;
  assign reuse_q   = '0;
  assign reuse_r   = '0;
`endif

  // Result for divides that finish on accept (zero divisor, overflow, reuse)
  always_comb begin
    if (div_zero)     special_res = in_rem ? req_rs1 : 32'hFFFF_FFFF;
    else if (div_ovf) special_res = in_rem ? 32'd0 : 32'h8000_0000;
    else              special_res = in_rem ? reuse_r : reuse_q;
  end

  // FSM with registered handshake outputs; flush overrides everything
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_rd    <= '0;
      busy       <= 1'b0;
      cnt        <= '0;
    end else if (flush) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            cnt       <= '0;
            if (!req_op[2]) begin
              state <= ST_MUL;
            end else if (div_zero || div_ovf || reuse_hit) begin
              state      <= ST_DONE;
              resp_valid <= 1'b1;
              resp_data  <= special_res;
              resp_rd    <= req_rd;
            end else begin
              state <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          if (cnt == 6'(MUL_LATENCY - 1)) begin
            state      <= ST_DONE;
            resp_valid <= 1'b1;
            resp_data  <= mul_res;
            resp_rd    <= req_q.rd;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        ST_DIV: begin
          if (cnt == 6'(DIV_ITERS - 1)) begin
            state <= ST_FIXUP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        ST_FIXUP: begin
          state      <= ST_DONE;
          resp_valid <= 1'b1;
          resp_data  <= req_q.op[1] ? r_fix : q_fix;
          resp_rd    <= req_q.rd;
        end
        ST_DONE: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operand capture on accept and divider iteration; data needs no reset
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && req_valid) begin
      req_q.op  <= md_op_t'(req_op);
      req_q.rs1 <= req_rs1;
      req_q.rs2 <= req_rs2;
      req_q.rd  <= req_rd;
      quo_q     <= neg_if(req_rs1, in_signed & req_rs1[31]);
      dvs_q     <= neg_if(req_rs2, in_signed & req_rs2[31]);
      rem_q     <= '0;
      q_neg     <= in_signed & (req_rs1[31] ^ req_rs2[31]);
      r_neg     <= in_signed & req_rs1[31];
    end else if (state == ST_DIV) begin
      quo_q <= iter_quo;
      rem_q <= iter_rem;
    end
  end

endmodule

// File: tb/tb_rv32_muldiv_unit.sv
// Self-checking bench for rv32_muldiv_unit: arithmetic reference model,
// per-cycle response monitor, directed corner cases and random operations.
// Honours RV32_MULDIV_RESULT_REUSE_EN for expected divide latency.
`timescale 1ns/1ps
module tb_rv32_muldiv_unit;

  localparam int DBPC    = 1;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 32 / DBPC + 1;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic [4:0]  req_rd = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        busy;

  always #5 clk = ~clk;

  rv32_muldiv_unit #(.DIV_BITS_PER_CYCLE(DBPC), .MUL_LATENCY(MUL_LAT)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_rd(resp_rd), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_data = '0;
  logic [4:0]  exp_rd   = '0;
  logic        mon_en   = 1'b0;

  // last completed full divide, as seen by the model
  logic        mdl_vld = 1'b0;
  logic [31:0] mdl_a = '0, mdl_b = '0;
  logic        mdl_sgn = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // RISC-V M-extension semantics computed with 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 0;
    case (op)
      OP_MUL:    begin p = sa * sb; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      OP_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      OP_REM: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Clock edges after the accept edge until resp_valid is seen
  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (!op[2]) return MUL_LAT;
    if (b == 0) return 0;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
`ifdef RV32_MULDIV_RESULT_REUSE_EN
    if (mdl_vld && mdl_a == a && mdl_b == b && mdl_sgn == ~op[0]) return 0;
`endif
    return DIV_LAT;
  endfunction

  // Response monitor: every cycle out of reset
  always @(negedge clk) begin
    if (rstn) begin
      check1("ready_vs_busy", req_ready, ~busy);
      if (resp_valid) begin
        if (mon_en) begin
          check("resp_data", resp_data, exp_data);
          check("resp_rd", {27'd0, resp_rd}, {27'd0, exp_rd});
        end else begin
          check1("resp_valid_unexpected", resp_valid, 1'b0);
        end
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int stall);
    int lat, elat;
    elat = ref_latency(op, a, b);
    @(negedge clk);
    check1("req_ready_idle", req_ready, 1'b1);
    exp_data  = ref_result(op, a, b);
    exp_rd    = rd;
    mon_en    = 1'b1;
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0; req_op = 3'($urandom); req_rs1 = $urandom; req_rs2 = $urandom;
    req_rd = 5'($urandom);
    lat = 0;
    while (!resp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(elat));
    if (resp_valid) begin
      for (int s = 0; s < stall; s++) begin
        check1("stall_req_ready", req_ready, 1'b0);
        @(negedge clk);
        check1("stall_resp_valid", resp_valid, 1'b1);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      mon_en     = 1'b0;
      check1("valid_after_hs", resp_valid, 1'b0);
      check1("ready_after_hs", req_ready, 1'b1);
    end
    if (op[2] && elat == DIV_LAT) begin
      mdl_vld = 1'b1; mdl_a = a; mdl_b = b; mdl_sgn = ~op[0];
    end
  endtask

  logic [2:0]  r_op;
  logic [31:0] r_a, r_b;
  logic [31:0] pool [6] = '{32'd1000, 32'hFFFF_FFF9, 32'd7, 32'd2, 32'h8000_0000, 32'hFFFF_FFFF};

  initial begin
    // reset state
    #12;
    check1("rst_req_ready", req_ready, 1'b1);
    check1("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_rd", {27'd0, resp_rd}, 32'd0);
    check1("rst_busy", busy, 1'b0);
    @(negedge clk); rstn = 1'b1;

    // hand-computed values pinning the model
    check("pin_mulh", ref_result(OP_MULH, 32'hFFFF_FFFE, 32'd3), 32'hFFFF_FFFF);
    check("pin_mulhu", ref_result(OP_MULHU, 32'hFFFF_FFFE, 32'd3), 32'h0000_0002);
    check("pin_div", ref_result(OP_DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("pin_rem", ref_result(OP_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("pin_divu0", ref_result(OP_DIVU, 32'd100, 32'd0), 32'hFFFF_FFFF);
    check("pin_remu0", ref_result(OP_REMU, 32'd100, 32'd0), 32'd100);
    check("pin_ovf", ref_result(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("pin_divu", ref_result(OP_DIVU, 32'd1000, 32'd7), 32'd142);
    check("pin_remsig", ref_result(OP_REM, 32'd1000, 32'd7), 32'd6);
    check("pin_mul", ref_result(OP_MUL, 32'd6, 32'd7), 32'd42);
    check("pin_mulhsu", ref_result(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);

    // directed operations
    run_op(OP_MULH,  32'hFFFF_FFFE, 32'd3, 5'd1, 0);
    run_op(OP_MULHU, 32'hFFFF_FFFE, 32'd3, 5'd2, 1);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 5'd3, 0);
    run_op(OP_REM,   32'hFFFF_FFF9, 32'd2, 5'd4, 0);
    run_op(OP_DIVU,  32'd100, 32'd0, 5'd5, 0);
    run_op(OP_REMU,  32'd100, 32'd0, 5'd6, 0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0);
    run_op(OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);
    run_op(OP_DIVU,  32'd1000, 32'd7, 5'd9, 5);
    run_op(OP_DIV,   32'd1000, 32'd7, 5'd10, 0);
    run_op(OP_REM,   32'd1000, 32'd7, 5'd11, 0);
    run_op(OP_MUL,   32'd3, 32'd5, 5'd0, 0);

    // flush in the middle of a divide
    @(negedge clk);
    mon_en = 1'b0;
    req_valid = 1'b1; req_op = OP_DIVU; req_rs1 = 32'd5000; req_rs2 = 32'd3; req_rd = 5'd12;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; mdl_vld = 1'b0;
    check1("flush_req_ready", req_ready, 1'b1);
    check1("flush_busy", busy, 1'b0);
    check1("flush_resp_valid", resp_valid, 1'b0);
    repeat (40) @(negedge clk);
    run_op(OP_MUL, 32'd6, 32'd7, 5'd13, 0);

    // flush beats a simultaneous accept
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_MUL; req_rs1 = 32'd9; req_rs2 = 32'd9; req_rd = 5'd14;
    flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check1("flush_acc_busy", busy, 1'b0);
    check1("flush_acc_ready", req_ready, 1'b1);
    repeat (5) @(negedge clk);

    // flush beats a simultaneous response handshake
    @(negedge clk);
    exp_data = ref_result(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); exp_rd = 5'd15; mon_en = 1'b1;
    req_valid = 1'b1; req_op = OP_MULHU; req_rs1 = 32'hFFFF_FFFF; req_rs2 = 32'hFFFF_FFFF; req_rd = 5'd15;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (MUL_LAT) @(negedge clk);
    check1("done_before_flush", resp_valid, 1'b1);
    flush = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; resp_ready = 1'b0; mon_en = 1'b0;
    check1("flush_done_valid", resp_valid, 1'b0);
    check1("flush_done_ready", req_ready, 1'b1);

    // asynchronous reset mid-divide
    run_op(OP_MUL, 32'd11, 32'd13, 5'd16, 0);
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_DIV; req_rs1 = 32'd77; req_rs2 = 32'd5; req_rd = 5'd17;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check1("arst_req_ready", req_ready, 1'b1);
    check1("arst_resp_valid", resp_valid, 1'b0);
    check("arst_resp_data", resp_data, 32'd0);
    check("arst_resp_rd", {27'd0, resp_rd}, 32'd0);
    check1("arst_busy", busy, 1'b0);
    mdl_vld = 1'b0;
    @(negedge clk); rstn = 1'b1;

    // randomized operations with biased operand classes
    for (int i = 0; i < 80; i++) begin
      r_op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: begin r_a = $urandom; r_b = 32'd0; end
        1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        2: begin r_a = pool[$urandom_range(0, 5)]; r_b = pool[$urandom_range(0, 5)]; end
        3: begin r_a = mdl_a; r_b = mdl_b; r_op = {1'b1, $urandom_range(0, 1) == 1, ~mdl_sgn}; end
        default: begin r_a = $urandom; r_b = $urandom >> $urandom_range(0, 31); end
      endcase
      run_op(r_op, r_a, r_b, 5'($urandom), $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
